// File: rtl/rsa_addsub_arb_if.sv
// rsa_addsub_arb_if
// Bundles the requester-side and add/sub-unit-side signals of the
// rsa_addsub_arb arbiter into one interface.
//   slave  modport : seen by the arbiter (requests and unit status in,
//                    grant / start / select / completion out)
//   master modport : seen by the requesters and the add/sub unit
// Signals:
//   iReq, iReqSub        per-requester request level and add(0)/sub(1) select
//   oGnt, oSel           one-hot grant and its binary index
//   oAsStart, oAsAddSub  start pulse and op select to the add/sub unit
//   iAsShift, iAsDone    unit's shift enable and done flag
//   oReqShift            shift enable routed to the granted requester
//   oReqDone             one-cycle completion pulse per requester
//   oBusy, oErr          operation in progress, sticky protocol error
interface rsa_addsub_arb_if #(
    parameter int NREQ = 2,
    parameter int SELW = 1
);
    logic [NREQ-1:0] iReq;
    logic [NREQ-1:0] iReqSub;
    logic [NREQ-1:0] oGnt;
    logic [SELW-1:0] oSel;
    logic            oAsStart;
    logic            oAsAddSub;
    logic            iAsShift;
    logic            iAsDone;
    logic [NREQ-1:0] oReqShift;
    logic [NREQ-1:0] oReqDone;
    logic            oBusy;
    logic            oErr;

    modport slave (
        input  iReq, iReqSub, iAsShift, iAsDone,
        output oGnt, oSel, oAsStart, oAsAddSub, oReqShift, oReqDone, oBusy, oErr
    );

    modport master (
        output iReq, iReqSub, iAsShift, iAsDone,
        input  oGnt, oSel, oAsStart, oAsAddSub, oReqShift, oReqDone, oBusy, oErr
    );
endinterface

// File: rtl/rsa_addsub_arb.sv
// rsa_addsub_arb
// Round-robin arbiter and sequencer sharing one word-serial 32-bit add/sub
// unit between NREQ requesters. Each granted operation streams NWORDS words
// (one 1024-bit add or subtract at the default size).
// Ports:
//   iClk   clock
//   iRstn  asynchronous active-low reset
//   bus    rsa_addsub_arb_if.slave: requests, grant, unit start/select,
//          shift routing, completion, busy and sticky error
// Parameters:
//   NREQ   number of requesters (2..8)
//   NWORDS words per operation, equal to the unit's counter period
//   SELW   width of oSel, clog2(NREQ) with a minimum of 1
module rsa_addsub_arb #(
    parameter int NREQ   = 2,
    parameter int NWORDS = 32,
    parameter int SELW   = 1
) (
    input logic                iClk,
    input logic                iRstn,
    rsa_addsub_arb_if.slave    bus
);

    localparam int            CW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]      state;
    logic [CW-1:0]   count;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] sel;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] req_done;
    logic            start;
    logic            add_sub;
    logic            err;

    logic [NREQ-1:0] masked;
    logic [SELW-1:0] win;
    logic [SELW-1:0] idx_sel;
    logic [NREQ-1:0] win_onehot;
    logic            win_valid;
    int              idx;

    // A requester finishing this cycle is masked out so it cannot be
    // regranted straight away; the search then walks upward from the
    // requester after the last winner and wraps, which gives round-robin.
    always_comb begin
        masked     = bus.iReq & ~req_done;
        win        = '0;
        win_valid  = 1'b0;
        idx        = 0;
        idx_sel    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_sel = SELW'(idx);
            if (!win_valid && masked[idx_sel]) begin
                win       = idx_sel;
                win_valid = 1'b1;
            end
        end
        win_onehot = win_valid ? (NREQ'(1) << win) : '0;
    end

    // Sequencer: IDLE grants and fires the start pulse, RUN counts words
    // and ends either on the expected done or on any done/count disagreement,
    // which is closed out like a normal end but latches the error flag.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state    <= IDLE;
            count    <= '0;
            ptr      <= SELW'(NREQ - 1);
            sel      <= '0;
            gnt      <= '0;
            req_done <= '0;
            start    <= 1'b0;
            add_sub  <= 1'b0;
            err      <= 1'b0;
        end else begin
            start    <= 1'b0;
            req_done <= '0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        gnt     <= win_onehot;
                        sel     <= win;
                        add_sub <= bus.iReqSub[win];
                        ptr     <= win;
                        start   <= 1'b1;
                        count   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    count <= count + CW'(1);
                    if (bus.iAsDone || (count == LAST)) begin
                        if (!(bus.iAsDone && (count == LAST))) begin
                            err <= 1'b1;
                        end
                        state    <= IDLE;
                        req_done <= gnt;
                        gnt      <= '0;
                        add_sub  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.oGnt      = gnt;
    assign bus.oSel      = sel;
    assign bus.oAsStart  = start;
    assign bus.oAsAddSub = add_sub;
    assign bus.oReqDone  = req_done;
    assign bus.oErr      = err;
    assign bus.oBusy     = (state == RUN);
    assign bus.oReqShift = {NREQ{bus.iAsShift}} & gnt;

endmodule

// File: tb/tb_rsa_addsub_arb.sv
// tb_rsa_addsub_arb
// Randomized bench for rsa_addsub_arb with three requesters. Each batch gives
// every requester a random number of operations with random add/sub selects;
// a round-robin reference model predicts the completion order, and a monitor
// checks grants, start timing, shift routing, completion latency and the
// error flag as the DUT presents them. A model of the add/sub unit drives
// shift/done and can plant early-done or missing-done faults.
module tb_rsa_addsub_arb;

    localparam int NREQ   = 3;
    localparam int NWORDS = 32;
    localparam int SELW   = 2;

    typedef struct {
        int req;
        bit sub;
        int words;
        bit err;
        int gap;
    } item_t;

    logic iClk;
    logic iRstn;

    rsa_addsub_arb_if #(.NREQ(NREQ), .SELW(SELW)) bus ();

    rsa_addsub_arb #(.NREQ(NREQ), .NWORDS(NWORDS), .SELW(SELW)) dut (
        .iClk  (iClk),
        .iRstn (iRstn),
        .bus   (bus)
    );

    item_t sb[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    issue_cyc = 0;
    int    done_word = NWORDS - 1;
    bit    model_err = 1'b0;
    int    model_last = NREQ - 1;
    int    remaining[NREQ];
    int    next_op[NREQ];
    bit    subs[NREQ][4];

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check_output(input string name, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Add/sub unit model: one shift per word starting with the start cycle,
    // done on word done_word (-1 means the done flag never comes).
    initial begin
        int w;
        bit running;
        w = 0;
        running = 1'b0;
        bus.iAsShift = 1'b0;
        bus.iAsDone  = 1'b0;
        forever begin
            @(negedge iClk);
            if (!iRstn) begin
                running = 1'b0;
            end else if (bus.oAsStart) begin
                running = 1'b1;
                w = 0;
            end
            if (running) begin
                bus.iAsShift = 1'b1;
                bus.iAsDone  = (w == done_word);
                if (w == done_word || w == NWORDS - 1) running = 1'b0;
                else w++;
            end else begin
                bus.iAsShift = 1'b0;
                bus.iAsDone  = 1'b0;
            end
        end
    end

    // Requesters: keep the request up until the last queued op completes,
    // presenting the next op's select after each completion.
    initial begin
        forever begin
            @(negedge iClk);
            for (int i = 0; i < NREQ; i++) begin
                if (iRstn && bus.oReqDone[i] && remaining[i] > 0) begin
                    remaining[i]--;
                    next_op[i]++;
                    if (remaining[i] == 0) bus.iReq[i] = 1'b0;
                    else bus.iReqSub[i] = subs[i][next_op[i]];
                end
            end
        end
    end

    // Monitor: checks the scoreboard head at every start and pops it at
    // every completion pulse.
    initial begin
        int    start_cyc;
        int    last_done;
        int    shifts[NREQ];
        int    others;
        item_t e;
        start_cyc = 0;
        last_done = -1;
        foreach (shifts[i]) shifts[i] = 0;
        forever begin
            @(negedge iClk);
            if (!iRstn) begin
                foreach (shifts[i]) shifts[i] = 0;
                last_done = -1;
                continue;
            end
            if (bus.oAsStart) begin
                start_cyc = cyc;
                foreach (shifts[i]) shifts[i] = 0;
                if (sb.size() > 0) begin
                    e = sb[0];
                    check_output("start_gnt", longint'(bus.oGnt), longint'(1) << e.req);
                    check_output("start_sel", longint'(bus.oSel), e.req);
                    check_output("start_addsub", longint'(bus.oAsAddSub), e.sub);
                    check_output("start_busy", longint'(bus.oBusy), 1);
                    if (e.gap < 0) check_output("req_to_start", cyc - issue_cyc, 1);
                    else if (e.gap > 0) check_output("done_to_start", cyc - last_done, e.gap);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.oReqShift[i]) shifts[i]++;
            end
            if (bus.oReqDone != '0) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_done", longint'(bus.oReqDone), 0);
                end else begin
                    e = sb.pop_front();
                    others = 0;
                    for (int i = 0; i < NREQ; i++) if (i != e.req) others += shifts[i];
                    check_output("done_vec", longint'(bus.oReqDone), longint'(1) << e.req);
                    check_output("shift_count", shifts[e.req], e.words);
                    check_output("stray_shift", others, 0);
                    check_output("start_to_done", cyc - start_cyc, e.words);
                    check_output("err_flag", longint'(bus.oErr), e.err);
                    check_output("done_gnt", longint'(bus.oGnt), 0);
                    check_output("done_busy", longint'(bus.oBusy), 0);
                end
                last_done = cyc;
            end
        end
    end

    // Issues one batch: mode 0 = good unit, 1 = done at word 20, 2 = no done.
    task automatic apply_stimulus(input int cnt[NREQ], input int mode);
        int    rem[NREQ];
        int    used[NREQ];
        int    w;
        int    prev;
        bit    first;
        bit    any;
        item_t it;
        @(negedge iClk);
        done_word = (mode == 1) ? 20 : ((mode == 2) ? -1 : NWORDS - 1);
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = cnt[i];
            used[i] = 0;
            remaining[i] = cnt[i];
            next_op[i] = 0;
            for (int k = 0; k < 4; k++) subs[i][k] = 1'($urandom_range(0, 1));
        end
        first = 1'b1;
        prev = -1;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            w = -1;
            for (int k = 1; k <= NREQ && w < 0; k++) begin
                if (rem[(model_last + k) % NREQ] > 0) w = (model_last + k) % NREQ;
            end
            if (w >= 0) begin
                any = 1'b1;
                it.req   = w;
                it.sub   = subs[w][used[w]];
                it.words = (mode == 1) ? 21 : NWORDS;
                it.err   = model_err | (mode != 0);
                it.gap   = first ? -1 : ((w == prev) ? 2 : 1);
                sb.push_back(it);
                if (mode != 0) model_err = 1'b1;
                rem[w]--;
                used[w]++;
                prev = w;
                first = 1'b0;
                model_last = w;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            bus.iReq[i]    = (cnt[i] > 0);
            bus.iReqSub[i] = subs[i][0];
        end
        issue_cyc = cyc;
    endtask

    task automatic wait_drain();
        int  n;
        bit  busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < 20 * NWORDS * 4) begin
            @(negedge iClk);
            n++;
            busy = (sb.size() != 0);
            for (int i = 0; i < NREQ; i++) if (remaining[i] != 0) busy = 1'b1;
        end
        if (busy) begin
            check_output("drain_timeout", sb.size(), 0);
            sb.delete();
            for (int i = 0; i < NREQ; i++) remaining[i] = 0;
            bus.iReq = '0;
        end
        repeat (3) @(negedge iClk);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_gnt"}, longint'(bus.oGnt), 0);
        check_output({tag, "_sel"}, longint'(bus.oSel), 0);
        check_output({tag, "_start"}, longint'(bus.oAsStart), 0);
        check_output({tag, "_addsub"}, longint'(bus.oAsAddSub), 0);
        check_output({tag, "_reqdone"}, longint'(bus.oReqDone), 0);
        check_output({tag, "_busy"}, longint'(bus.oBusy), 0);
        check_output({tag, "_err"}, longint'(bus.oErr), 0);
        check_output({tag, "_reqshift"}, longint'(bus.oReqShift), 0);
    endtask

    // Reset between clock edges; outputs must clear without waiting for a clock.
    task automatic do_reset(input string tag);
        @(negedge iClk);
        #2;
        iRstn = 1'b0;
        bus.iReq = '0;
        for (int i = 0; i < NREQ; i++) remaining[i] = 0;
        model_err = 1'b0;
        model_last = NREQ - 1;
        #1;
        check_all_zero(tag);
        @(negedge iClk);
        iRstn = 1'b1;
        repeat (2) @(negedge iClk);
    endtask

    initial begin
        int cnt[NREQ];
        int n;
        iRstn = 1'b0;
        bus.iReq = '0;
        bus.iReqSub = '0;
        for (int i = 0; i < NREQ; i++) begin
            remaining[i] = 0;
            next_op[i] = 0;
        end
        repeat (3) @(negedge iClk);
        check_all_zero("reset");
        iRstn = 1'b1;
        repeat (2) @(negedge iClk);

        $display("[TB] single op, round-robin, release masking");
        apply_stimulus('{1, 0, 0}, 0); wait_drain();
        apply_stimulus('{2, 2, 0}, 0); wait_drain();
        apply_stimulus('{3, 3, 3}, 0); wait_drain();
        apply_stimulus('{3, 0, 0}, 0); wait_drain();
        apply_stimulus('{0, 1, 2}, 0); wait_drain();

        $display("[TB] random batches");
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < NREQ; i++) cnt[i] = $urandom_range(0, 3);
            apply_stimulus(cnt, 0);
            wait_drain();
        end

        $display("[TB] protocol faults");
        apply_stimulus('{1, 0, 0}, 1); wait_drain();
        apply_stimulus('{1, 1, 1}, 0); wait_drain();
        apply_stimulus('{0, 1, 0}, 2); wait_drain();
        apply_stimulus('{2, 0, 1}, 0); wait_drain();

        $display("[TB] async reset mid-operation");
        @(negedge iClk);
        done_word = NWORDS - 1;
        bus.iReq = 3'b001;
        n = 0;
        while (!bus.oAsStart && n < 10) begin
            @(negedge iClk);
            n++;
        end
        check_output("reset_test_start_seen", longint'(bus.oAsStart), 1);
        repeat (9) @(negedge iClk);
        #2;
        iRstn = 1'b0;
        bus.iReq = '0;
        model_err = 1'b0;
        model_last = NREQ - 1;
        #1;
        check_all_zero("midrun");
        @(negedge iClk);
        iRstn = 1'b1;
        repeat (2) @(negedge iClk);
        apply_stimulus('{0, 1, 0}, 0); wait_drain();
        apply_stimulus('{1, 0, 0}, 0); wait_drain();
        do_reset("idle_reset");
        apply_stimulus('{1, 1, 0}, 0); wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
